seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Purpose:
//   Watches the multiplexed cathode/anode drive of an 8-digit, active-low
//   seven-segment display and rebuilds the 32-bit hex value being shown.
//   Each anode/segment pair is registered, debounced by a stability counter,
//   decoded, and collected digit by digit. A complete frame starts at
//   digit 0 and ends when all eight digits have been seen.
//
// Ports:
//   clk_100Mhz_pi  in   1   clock, rising edge
//   reset_pi       in   1   synchronous reset, active-low
//   seg_pi         in   7   cathodes, active-low, bit6=g .. bit0=a
//   an_pi          in   8   anodes, active-low, bit i selects digit i
//   clr_err_pi     in   1   clears the sticky error bits
//   value_po       out  32  last complete frame, digit i in [4i+3:4i]
//   valid_po       out  1   one-cycle pulse when value_po updates
//   changed_po     out  1   pulse with valid_po when the value differs
//   err_po         out  3   sticky {order_err, seg_err, an_err}
//
// Parameters:
//   STABLE_CYCLES  clocks a pair must hold before it is sampled (2..255)
//
// Configuration macro:
//   SEG7_DECODE_ORDER_CHECK_EN  when defined, digits inside a frame must
//   arrive in ascending order; otherwise any order is accepted and
//   order_err is tied to 0.
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk_100Mhz_pi,
    input  logic        reset_pi,
    input  logic [6:0]  seg_pi,
    input  logic [7:0]  an_pi,
    input  logic        clr_err_pi,
    output logic [31:0] value_po,
    output logic        valid_po,
    output logic        changed_po,
    output logic [2:0]  err_po
);

    typedef enum logic {
        ST_SYNC,
        ST_COLLECT
    } state_t;

    localparam logic [7:0] STABLE_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);

    // Saturating increment of the stability counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= STABLE_SAT) ? STABLE_SAT : c + 8'd1;
    endfunction

    // Active-low segment pattern to {hit, nibble}; hit=0 for unknown patterns.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0011000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // ---- stage p0: registered pin pair and stability counter ----
    logic [6:0] r_seg_p0;
    logic [7:0] r_an_p0;
    logic [7:0] r_cnt_p0;
    logic       w_pair_chg;

    // The counter restarts on the same edge that loads a different pair, so
    // r_cnt_p0 is the number of extra edges the current pair has survived.
    assign w_pair_chg = ({seg_pi, an_pi} != {r_seg_p0, r_an_p0});

    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_pi) begin
            r_seg_p0 <= 7'h7F;
            r_an_p0  <= 8'hFF;
            r_cnt_p0 <= 8'd0;
        end else begin
            r_seg_p0 <= seg_pi;
            r_an_p0  <= an_pi;
            r_cnt_p0 <= w_pair_chg ? 8'd0 : sat_inc(r_cnt_p0);
        end
    end

    // ---- stage p1: capture strobe, decode, frame assembly ----
    logic       w_vld_p1;
    logic [7:0] w_an_act;
    logic       w_an_blank;
    logic       w_an_one;
    logic [2:0] w_an_idx;
    logic [4:0] w_seg_dec;
    logic       w_seg_hit;
    logic [3:0] w_nib;
    logic       w_dig_vld;
    logic       w_an_err_evt;
    logic       w_seg_err_evt;

    // Fires on the single cycle where the counter steps up to STABLE_CYCLES;
    // saturation keeps it from firing again during a long dwell.
    assign w_vld_p1   = (r_cnt_p0 == STABLE_M1);

    assign w_an_act   = ~r_an_p0;
    assign w_an_blank = (r_an_p0 == 8'hFF);
    assign w_an_one   = !w_an_blank && ((w_an_act & (w_an_act - 8'd1)) == 8'd0);

    always_comb begin
        w_an_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_an_act[k]) w_an_idx = 3'(k);
        end
    end

    assign w_seg_dec     = seg_decode(r_seg_p0);
    assign w_seg_hit     = w_seg_dec[4];
    assign w_nib         = w_seg_dec[3:0];

    // Blank (all anodes off) is a normal scan gap: no segment check.
    assign w_an_err_evt  = w_vld_p1 && !w_an_blank && !w_an_one;
    assign w_seg_err_evt = w_vld_p1 && !w_an_blank && !w_seg_hit;
    assign w_dig_vld     = w_vld_p1 && w_an_one && w_seg_hit;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_shadow;
    logic [31:0] w_shadow_nxt;
    logic [7:0]  r_seen;
    logic [7:0]  w_seen_nxt;
    logic        w_done;
    logic        w_order_evt;
    logic        w_accept;
`ifdef SEG7_DECODE_ORDER_CHECK_EN
    logic [2:0]  r_last_idx;
    logic [2:0]  w_last_nxt;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_seen_nxt   = r_seen;
        w_done       = 1'b0;
        w_order_evt  = 1'b0;
        w_accept     = 1'b0;
`ifdef SEG7_DECODE_ORDER_CHECK_EN
        w_last_nxt   = r_last_idx;
`endif
        case (r_state)
            ST_SYNC: begin
                // Only digit 0 can open a frame.
                if (w_dig_vld && (w_an_idx == 3'd0)) begin
                    w_shadow_nxt[3:0] = w_nib;
                    w_seen_nxt        = 8'h01;
                    w_state_nxt       = ST_COLLECT;
`ifdef SEG7_DECODE_ORDER_CHECK_EN
                    w_last_nxt        = 3'd0;
`endif
                end
            end
            default: begin
                if (w_dig_vld) begin
                    w_accept = 1'b1;
`ifdef SEG7_DECODE_ORDER_CHECK_EN
                    if (w_an_idx != r_last_idx + 3'd1) begin
                        w_accept    = 1'b0;
                        w_order_evt = 1'b1;
                        if (w_an_idx == 3'd0) begin
                            // Out-of-order digit 0 restarts the frame at once.
                            w_shadow_nxt[3:0] = w_nib;
                            w_seen_nxt        = 8'h01;
                            w_last_nxt        = 3'd0;
                        end else begin
                            w_seen_nxt  = 8'h00;
                            w_state_nxt = ST_SYNC;
                        end
                    end
`endif
                end
                if (w_accept) begin
                    w_shadow_nxt[{w_an_idx, 2'b00} +: 4] = w_nib;
                    w_seen_nxt = r_seen | (8'h01 << w_an_idx);
`ifdef SEG7_DECODE_ORDER_CHECK_EN
                    w_last_nxt = w_an_idx;
`endif
                    if (w_seen_nxt == 8'hFF) begin
                        w_done      = 1'b1;
                        w_seen_nxt  = 8'h00;
                        w_state_nxt = ST_SYNC;
                    end
                end
            end
        endcase
    end

    // ---- stage p2: published frame, pulses and sticky errors ----
    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_pi) begin
            r_state    <= ST_SYNC;
            r_shadow   <= 32'd0;
            r_seen     <= 8'd0;
            value_po   <= 32'd0;
            valid_po   <= 1'b0;
            changed_po <= 1'b0;
            err_po     <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_seen     <= w_seen_nxt;
            valid_po   <= w_done;
            // Compared against the frame being replaced, before overwrite.
            changed_po <= w_done && (w_shadow_nxt != value_po);
            if (w_done) value_po <= w_shadow_nxt;
            // A new event in the clear cycle keeps its bit set.
            err_po     <= (err_po & ~{3{clr_err_pi}})
                        | {w_order_evt, w_seg_err_evt, w_an_err_evt};
        end
    end

`ifdef SEG7_DECODE_ORDER_CHECK_EN
    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_pi) r_last_idx <= 3'd0;
        else           r_last_idx <= w_last_nxt;
    end
`endif

endmodule
